// File: rtl/tff_counter_pkg.sv
// Shared definitions for the T-flip-flop counter: the 2-bit operating mode encoding.
package tff_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_t;

endpackage

// File: rtl/tff_counter_if.sv
// Control/status bundle of tff_counter; master drives the controls, slave is the counter.
interface tff_counter_if #(
    parameter int WIDTH = 8
);
    import tff_counter_pkg::*;

    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] t_mask;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, t_mask, load, load_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, mode, t_mask, load, load_val,
        output q, tc, wrap
    );

endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles on a rising clk edge when t is high, async active-high reset to 0.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_counter.sv
// Up/down/masked-toggle counter built from T flip-flops, bounded to 0..MAX_VAL.
// Define TFF_COUNTER_SAT_EN to make up/down counting saturate instead of wrapping.
module tff_counter
    import tff_counter_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input logic          clk,
    input logic          rst,
    tff_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] toggled;
    logic             wrap_d;
    logic             wrap_q;

    // The desired next count is computed here; the cells only see which bits must flip.
    always_comb begin
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        toggled = cnt_q ^ bus.t_mask;
        if (bus.load) begin
            cnt_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_UP: begin
                    if (cnt_q == MAX_VAL) begin
                        wrap_d = 1'b1;
`ifdef TFF_COUNTER_SAT_EN
                        cnt_d  = MAX_VAL;
`else
                        cnt_d  = ZERO;
`endif
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                MODE_DOWN: begin
                    if (cnt_q == ZERO) begin
                        wrap_d = 1'b1;
`ifdef TFF_COUNTER_SAT_EN
                        cnt_d  = ZERO;
`else
                        cnt_d  = MAX_VAL;
`endif
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                MODE_TOGGLE: begin
                    cnt_d = (toggled > MAX_VAL) ? MAX_VAL : toggled;
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    assign t_vec = cnt_q ^ cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[i]),
            .q   (cnt_q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    // Terminal count looks only at q and mode so it is valid even while en is low.
    assign bus.tc   = ((bus.mode == MODE_UP)   && (cnt_q == MAX_VAL)) ||
                      ((bus.mode == MODE_DOWN) && (cnt_q == ZERO));
    assign bus.q    = cnt_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_tff_counter.sv
// Scoreboard bench for tff_counter (WIDTH=4, MAX_VAL=9); honours TFF_COUNTER_SAT_EN like the design.
module tb_tff_counter;
    import tff_counter_pkg::*;

    localparam int WIDTH = 4;
    localparam int MAXV  = 9;

    typedef struct {
        int q;
        int wrap;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   m_q    = 0;
    exp_t sb[$];

    tff_counter_if #(.WIDTH(WIDTH)) bus ();

    tff_counter #(
        .WIDTH   (WIDTH),
        .MAX_VAL (4'(MAXV))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int modelTc(input int q, input int mode);
        return ((mode == 1 && q == MAXV) || (mode == 2 && q == 0)) ? 1 : 0;
    endfunction

    // Reference behaviour in plain integer arithmetic, independent of the bit-level design.
    function automatic exp_t modelNext(input int q, input bit en, input int mode,
                                       input int mask, input bit load, input int lval);
        exp_t r;
        r.q    = q;
        r.wrap = 0;
        if (load) begin
            r.q = (lval > MAXV) ? MAXV : lval;
        end else if (en) begin
            case (mode)
                1: begin
`ifdef TFF_COUNTER_SAT_EN
                    if (q == MAXV) r.wrap = 1;
                    else r.q = q + 1;
`else
                    r.q    = (q + 1) % (MAXV + 1);
                    r.wrap = (r.q == 0) ? 1 : 0;
`endif
                end
                2: begin
`ifdef TFF_COUNTER_SAT_EN
                    if (q == 0) r.wrap = 1;
                    else r.q = q - 1;
`else
                    r.q    = (q + MAXV) % (MAXV + 1);
                    r.wrap = (q == 0) ? 1 : 0;
`endif
                end
                3: begin
                    r.q = q ^ mask;
                    if (r.q > MAXV) r.q = MAXV;
                end
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic applyStimulus(input string tag, input bit en, input int mode,
                                 input int mask, input bit load, input int lval);
        exp_t e;
        exp_t want;
        logic [1:0]       mode_bits;
        logic [WIDTH-1:0] mask_bits;
        logic [WIDTH-1:0] lval_bits;
        mode_bits = mode[1:0];
        mask_bits = mask[WIDTH-1:0];
        lval_bits = lval[WIDTH-1:0];
        @(negedge clk);
        bus.en       = en;
        bus.mode     = mode_t'(mode_bits);
        bus.t_mask   = mask_bits;
        bus.load     = load;
        bus.load_val = lval_bits;
        #1;
        checkOutput($sformatf("%s.tc", tag), int'(bus.tc), modelTc(m_q, int'(mode_bits)));
        e = modelNext(m_q, en, int'(mode_bits), int'(mask_bits), load, int'(lval_bits));
        sb.push_back(e);
        m_q = e.q;
        @(posedge clk);
        #1;
        want = sb.pop_front();
        checkOutput($sformatf("%s.q", tag), int'(bus.q), want.q);
        checkOutput($sformatf("%s.wrap", tag), int'(bus.wrap), want.wrap);
    endtask

    // Reset lands mid-cycle with load/en active and spans a clock edge that must be ignored.
    task automatic pulseReset(input string tag);
        @(negedge clk);
        bus.load     = 1'b1;
        bus.load_val = 4'd7;
        bus.en       = 1'b1;
        #2 rst = 1'b1;
        #1;
        checkOutput($sformatf("%s.async_q", tag), int'(bus.q), 0);
        checkOutput($sformatf("%s.async_wrap", tag), int'(bus.wrap), 0);
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s.held_q", tag), int'(bus.q), 0);
        checkOutput($sformatf("%s.held_wrap", tag), int'(bus.wrap), 0);
        @(negedge clk);
        rst      = 1'b0;
        bus.load = 1'b0;
        bus.en   = 1'b0;
        m_q      = 0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.mode     = MODE_HOLD;
        bus.t_mask   = '0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        #1;
        checkOutput("reset.q", int'(bus.q), 0);
        checkOutput("reset.wrap", int'(bus.wrap), 0);
        checkOutput("reset.tc", int'(bus.tc), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) applyStimulus("up", 1'b1, 1, 0, 1'b0, 0);

        applyStimulus("load15", 1'b0, 0, 0, 1'b1, 15);
        for (int i = 0; i < 11; i++) applyStimulus("down", 1'b1, 2, 0, 1'b0, 0);

        applyStimulus("load5", 1'b0, 0, 0, 1'b1, 5);
        applyStimulus("tog3", 1'b1, 3, 4'b0011, 1'b0, 0);
        applyStimulus("tog8", 1'b1, 3, 4'b1000, 1'b0, 0);

        applyStimulus("load7", 1'b0, 0, 0, 1'b1, 7);
        applyStimulus("prio", 1'b1, 1, 0, 1'b1, 2);

        applyStimulus("load9", 1'b0, 0, 0, 1'b1, 9);
        applyStimulus("hold", 1'b0, 1, 0, 1'b0, 0);
        applyStimulus("hold2", 1'b0, 1, 0, 1'b0, 0);

        applyStimulus("rev_up", 1'b1, 1, 0, 1'b0, 0);
        applyStimulus("rev_dn", 1'b1, 2, 0, 1'b0, 0);

        applyStimulus("preload9", 1'b0, 0, 0, 1'b1, 9);
        applyStimulus("edge", 1'b1, 1, 0, 1'b0, 0);
        pulseReset("rst_wrap");

        applyStimulus("load0", 1'b0, 0, 0, 1'b1, 0);
        for (int i = 0; i < 4; i++) applyStimulus("cnt4", 1'b1, 1, 0, 1'b0, 0);
        pulseReset("rst_mid");
        for (int i = 0; i < 3; i++) applyStimulus("resume", 1'b1, 1, 0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                          int'($urandom_range(0, 15)));
        end

        checkOutput("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tff_counter.md
TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter/register width in bits (legal range 2..32).
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, highest legal count value (legal range 1..2**WIDTH-1).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  count/toggle enable; when low the state holds.
REQ-006 mode  input  2  operation: 00 hold, 01 up, 10 down, 11 masked toggle.
REQ-007 t_mask  input  WIDTH  per-bit toggle request, used only in mode 11.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value captured on load.
REQ-010 q  output  WIDTH  current state, registered.
REQ-011 tc  output  1  terminal count, combinational from q and mode.
REQ-012 wrap  output  1  one-cycle registered pulse on wrap or saturation event.

Function
REQ-013 The block SHALL be a synchronous state machine whose state bits are T-type cells; each next state is realised as T = q XOR next.
REQ-014 Priority per rising edge SHALL be load > en; with load high, q <= min(load_val, MAX_VAL), and wrap <= 0.
REQ-015 With load low and en low, or mode 00, q SHALL hold and wrap <= 0.
REQ-016 Mode 01 SHALL set q <= q+1; at q==MAX_VAL, q <= 0 and wrap <= 1.
REQ-017 Mode 10 SHALL set q <= q-1; at q==0, q <= MAX_VAL and wrap <= 1.
REQ-018 Mode 11 SHALL set q <= q XOR t_mask; if the result exceeds MAX_VAL, q <= MAX_VAL; wrap <= 0.
REQ-019 tc SHALL be 1 when (mode==01 and q==MAX_VAL) or (mode==10 and q==0), else 0, independent of en.
REQ-020 Latency: q and wrap reflect an input change on the first rising clk edge after it; tc has zero latency.
REQ-021 wrap SHALL be high for exactly one cycle per event; consecutive events (e.g. MAX_VAL=1) produce consecutive pulses.
REQ-022 Mode changes SHALL take effect on the same edge with no pipeline; up-to-down reversal at any q is legal.
REQ-023 Arithmetic SHALL be WIDTH-bit unsigned; no intermediate result is observable outside 0..MAX_VAL.

Reset
REQ-024 rst high SHALL force q=0 and wrap=0 immediately, regardless of clk.
REQ-025 While rst is high, load, en and clk edges SHALL be ignored.
REQ-026 After rst deasserts, the first rising clk edge SHALL perform a normal update; reset mid-count discards the count.

Configuration
REQ-027 Macro TFF_COUNTER_SAT_EN, when defined, SHALL make modes 01/10 saturate: hold at MAX_VAL (up) or 0 (down), and pulse wrap on each blocked attempt.
REQ-028 Without TFF_COUNTER_SAT_EN, modes 01/10 SHALL wrap per REQ-016/REQ-017.
REQ-029 Port list and the tc definition SHALL be identical in both builds.

Structure
REQ-030 Package tff_counter_pkg SHALL hold the mode encoding constants (MODE_HOLD, MODE_UP, MODE_DOWN, MODE_TOGGLE) and their 2-bit typedef.
REQ-031 Sub-module tff_cell (1-bit T flip-flop, async active-high reset to 0, input t, output q) SHALL be instantiated WIDTH times.
REQ-032 Next-state, clamping and wrap logic SHALL reside in tff_counter; tff_cell SHALL contain no mode logic.

Verification (WIDTH=4, MAX_VAL=9)
REQ-033 Reset then mode=01, en=1 for 12 cycles -> q: 0..9,0,1; wrap high only on the 9->0 edge; tc=1 while q==9.
REQ-034 load=1, load_val=15 -> q=9; then mode=10 for 11 cycles -> q 8..0,9,8; wrap on 0->9; with SAT_EN, q sticks at 0 and wrap pulses each blocked cycle.
REQ-035 q=5, mode=11, t_mask=0011 -> q=6; t_mask=1000 from q=6 -> 14 clamped to 9.
REQ-036 q=7, load=1 and en=1 with mode=01, load_val=2 on the same edge -> q=2 (load wins), wrap=0.
REQ-037 rst pulsed mid-cycle while q=4 and counting -> q=0 and wrap=0 before the next clk edge; counting resumes from 0 after release.
REQ-038 en=0, mode=01, q=9 -> q holds at 9, tc=1, wrap=0.
